// File: rtl/synapse_pkg.sv
// Shared types and default sizing for the synapse scheduler.
package synapse_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_e;

  localparam int DEF_NCH   = 8;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNTW  = 8;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after last_i+1 (mod p_nch).
module rr_arbiter #(
  parameter int p_nch = 8,
  parameter int p_chw = $clog2(p_nch)
) (
  input  logic [p_nch-1:0] req_i,
  input  logic [p_chw-1:0] last_i,
  output logic [p_nch-1:0] gnt_o,
  output logic [p_chw-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    logic [p_chw-1:0] c;
    c     = '0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < p_nch; i++) begin
      c = p_chw'((int'(last_i) + 1 + i) % p_nch);
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = c;
      end
    end
  end

endmodule

// File: rtl/synapse_scheduler.sv
// Serialises per-channel spike pulses into a valid/ready weight stream.
// Define SYNAPSE_SCHED_DROPCNT_EN to build the saturating lost-spike counter.
module synapse_scheduler
  import synapse_pkg::*;
#(
  parameter int p_nch   = DEF_NCH,
  parameter int p_width = DEF_WIDTH,
  parameter int p_cntw  = DEF_CNTW
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [p_nch-1:0]           i_event,
  input  logic [p_nch*p_width-1:0]   i_weight,
  input  logic                       i_ready,
  output logic [p_nch-1:0]           o_clr,
  output logic                       o_valid,
  output logic [p_width-1:0]         o_weight,
  output logic [$clog2(p_nch)-1:0]   o_ch,
  output logic [p_cntw-1:0]          o_drop_cnt
);

  localparam int CHW = $clog2(p_nch);

  sched_state_e       state_q;
  logic [p_nch-1:0]   pending_q, pending_d;
  logic [p_nch-1:0]   clr_q;
  logic               valid_q;
  logic [CHW-1:0]     ch_q, last_q;
  logic [p_width-1:0] weight_q;

  logic [p_nch-1:0]   gnt_oh, grant_mask;
  logic [CHW-1:0]     gnt_idx;
  logic               gnt_any, handshake, do_grant;
  logic [p_width-1:0] weight_arr [p_nch];

  for (genvar gi = 0; gi < p_nch; gi++) begin : g_wsplit
    assign weight_arr[gi] = i_weight[gi*p_width +: p_width];
  end

  rr_arbiter #(.p_nch(p_nch), .p_chw(CHW)) u_arb (
    .req_i  (pending_q),
    .last_i (last_q),
    .gnt_o  (gnt_oh),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  // A new grant may follow a completed handshake in the same cycle.
  assign handshake  = valid_q & i_ready;
  assign do_grant   = gnt_any & ((state_q == IDLE) | handshake);
  assign grant_mask = do_grant ? gnt_oh : '0;
  // Set wins over the grant clear, so a spike landing on its own grant is kept.
  assign pending_d  = (pending_q & ~grant_mask) | i_event;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      clr_q     <= '0;
      valid_q   <= 1'b0;
      ch_q      <= '0;
      weight_q  <= '0;
      last_q    <= CHW'(p_nch - 1);
    end else begin
      pending_q <= pending_d;
      clr_q     <= i_event;
      case (state_q)
        IDLE:  if (do_grant) state_q <= ISSUE;
        ISSUE: if (handshake && !do_grant) state_q <= IDLE;
      endcase
      if (do_grant) begin
        valid_q  <= 1'b1;
        ch_q     <= gnt_idx;
        weight_q <= weight_arr[gnt_idx];
        last_q   <= gnt_idx;
      end else if (handshake) begin
        valid_q  <= 1'b0;
      end
    end
  end

  assign o_clr    = clr_q;
  assign o_valid  = valid_q;
  assign o_ch     = ch_q;
  assign o_weight = weight_q;

`ifdef SYNAPSE_SCHED_DROPCNT_EN
  localparam logic [p_cntw+6:0] CNT_MAX = (p_cntw+7)'({p_cntw{1'b1}});

  logic [p_nch-1:0]  drop;
  logic [p_cntw+6:0] drop_sum;
  logic [p_cntw-1:0] drop_cnt_q, drop_cnt_d;

  assign drop       = i_event & pending_q & ~grant_mask;
  assign drop_sum   = (p_cntw+7)'(drop_cnt_q) + (p_cntw+7)'(popcount32(32'(drop)));
  assign drop_cnt_d = (drop_sum > CNT_MAX) ? {p_cntw{1'b1}} : drop_sum[p_cntw-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_synapse_scheduler.sv
// Directed bench for synapse_scheduler with a queue-based scoreboard.
module tb_synapse_scheduler;

  localparam int NCH = 8;
  localparam int W   = 8;
  localparam int CW  = 2;

`ifdef SYNAPSE_SCHED_DROPCNT_EN
  localparam int EXP_DROP3   = 3;
  localparam int EXP_DROPSAT = 3;
`else
  localparam int EXP_DROP3   = 0;
  localparam int EXP_DROPSAT = 0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NCH-1:0]     ev = '0;
  logic [NCH*W-1:0]   wt = '0;
  logic               rdy = 1'b0;
  logic [NCH-1:0]     o_clr;
  logic               o_valid;
  logic [W-1:0]       o_weight;
  logic [2:0]         o_ch;
  logic [CW-1:0]      o_drop_cnt;

  synapse_scheduler #(.p_nch(NCH), .p_width(W), .p_cntw(CW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_event    (ev),
    .i_weight   (wt),
    .i_ready    (rdy),
    .o_clr      (o_clr),
    .o_valid    (o_valid),
    .o_weight   (o_weight),
    .o_ch       (o_ch),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    int         ch;
    logic [W-1:0] w;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [W-1:0] wof(input int seed, input int k);
    return W'(seed + 3 * k);
  endfunction

  task automatic set_w(input int seed);
    for (int k = 0; k < NCH; k++) wt[k*W +: W] = wof(seed, k);
  endtask

  task automatic push(input int ch, input int seed);
    sb_q.push_back('{ch: ch, w: wof(seed, ch)});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  // Monitor: pops on every handshake and checks stability while stalled.
  initial begin
    logic         held;
    logic [2:0]   h_ch;
    logic [W-1:0] h_w;
    exp_t         e;
    held = 1'b0;
    h_ch = '0;
    h_w  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else if (o_valid) begin
        if (held) begin
          chk("hold_ch", 32'(o_ch), 32'(h_ch));
          chk("hold_weight", 32'(o_weight), 32'(h_w));
        end
        if (rdy) begin
          chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            $display("tx t=%0t ch=%0d weight=%0h exp_ch=%0d exp_weight=%0h", $time, o_ch, o_weight, e.ch, e.w);
            chk("tx_ch", 32'(o_ch), 32'(e.ch));
            chk("tx_weight", 32'(o_weight), 32'(e.w));
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          h_ch = o_ch;
          h_w  = o_weight;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) tick;
    at_neg;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_clr", 32'(o_clr), 32'd0);
    chk("rst_ch", 32'(o_ch), 32'd0);
    chk("rst_weight", 32'(o_weight), 32'd0);
    chk("rst_drop", 32'(o_drop_cnt), 32'd0);
    tick;
    rst_n = 1'b1;

    // Round-robin burst from reset: channels 0..7 back to back
    tick;
    set_w(16); ev = 8'hFF; rdy = 1'b1;
    for (int k = 0; k < NCH; k++) push(k, 16);
    tick;
    ev = '0;
    at_neg;
    chk("rr_clr", 32'(o_clr), 32'hFF);
    chk("rr_latency", 32'(o_valid), 32'd0);
    for (int i = 0; i < NCH; i++) begin
      tick;
      at_neg;
      chk("rr_valid", 32'(o_valid), 32'd1);
    end
    tick;
    at_neg;
    chk("rr_done", 32'(o_valid), 32'd0);

    // Single spike on channel 2
    tick;
    set_w(64); ev = 8'h04; push(2, 64);
    tick;
    ev = '0;
    at_neg;
    chk("single_clr", 32'(o_clr), 32'h04);
    chk("single_latency", 32'(o_valid), 32'd0);
    tick;
    at_neg;
    chk("single_valid", 32'(o_valid), 32'd1);
    chk("single_ch", 32'(o_ch), 32'd2);
    chk("single_clr_gone", 32'(o_clr), 32'd0);
    tick;
    at_neg;
    chk("single_done", 32'(o_valid), 32'd0);

    // Backpressure: ch4 held, weights change underneath, ch5 follows release
    tick;
    rdy = 1'b0; set_w(100); ev = 8'h30;
    push(4, 100); push(5, 160);
    tick;
    ev = '0;
    tick;
    set_w(160);
    at_neg;
    chk("bp_valid", 32'(o_valid), 32'd1);
    chk("bp_ch", 32'(o_ch), 32'd4);
    repeat (5) tick;
    rdy = 1'b1;
    tick;
    at_neg;
    chk("bp_next_valid", 32'(o_valid), 32'd1);
    chk("bp_next_ch", 32'(o_ch), 32'd5);
    tick;
    at_neg;
    chk("bp_done", 32'(o_valid), 32'd0);

    // Drops: ch1 stalled, ch3 pending, ch3 re-pulsed 3 then 2 more times
    tick;
    rdy = 1'b0; set_w(40); ev = 8'h0A;
    push(1, 40); push(3, 40);
    tick;
    ev = '0;
    tick;
    for (int i = 0; i < 3; i++) begin
      tick; ev = 8'h08;
      tick; ev = '0;
    end
    at_neg;
    chk("drop_cnt3", 32'(o_drop_cnt), 32'(EXP_DROP3));
    for (int i = 0; i < 2; i++) begin
      tick; ev = 8'h08;
      tick; ev = '0;
    end
    at_neg;
    chk("drop_sat", 32'(o_drop_cnt), 32'(EXP_DROPSAT));
    tick;
    rdy = 1'b1;
    tick;
    at_neg;
    chk("drop_drain_ch", 32'(o_ch), 32'd3);
    tick;
    at_neg;
    chk("drop_drain_done", 32'(o_valid), 32'd0);

    // Reset in the middle of a stalled issue with a fresh o_clr pulse
    tick;
    rdy = 1'b0; ev = 8'h60;
    tick;
    ev = '0;
    tick;
    ev = 8'h01;
    tick;
    ev = '0;
    at_neg;
    chk("mid_valid", 32'(o_valid), 32'd1);
    chk("mid_clr", 32'(o_clr), 32'h01);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_ch", 32'(o_ch), 32'd0);
    chk("mid_rst_weight", 32'(o_weight), 32'd0);
    chk("mid_rst_clr", 32'(o_clr), 32'd0);
    chk("mid_rst_drop", 32'(o_drop_cnt), 32'd0);
    sb_q.delete();
    tick;
    tick;
    rst_n = 1'b1;
    repeat (3) tick;
    at_neg;
    chk("post_rst_valid", 32'(o_valid), 32'd0);
    chk("post_rst_clr", 32'(o_clr), 32'd0);

    // First grant after reset is ch0; a ch0 spike on its grant edge is kept
    tick;
    rdy = 1'b1; set_w(80); ev = 8'h81;
    push(0, 80); push(7, 80); push(0, 80);
    tick;
    ev = 8'h01;
    tick;
    ev = '0;
    at_neg;
    chk("post_first_ch", 32'(o_ch), 32'd0);
    chk("post_first_valid", 32'(o_valid), 32'd1);
    repeat (3) tick;
    at_neg;
    chk("setwin_done", 32'(o_valid), 32'd0);
    chk("setwin_nodrop", 32'(o_drop_cnt), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
